fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: stored mantissa field width, excluding the hidden bit; the word width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands a and b are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: the block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, W each: IEEE-style operands, fields {sign, exp, man}.
REQ-008 SHALL have port out_valid, output, 1: result and flags are valid.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-010 SHALL have port result, output, W: the product.
REQ-011 SHALL have port flags, output, 3: {invalid, overflow, underflow}, aligned with result.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 decode/classify + exponent sum; S2 (MAN_W+1)x(MAN_W+1) mantissa multiply; S3 normalise, round, pack, special-case select.
REQ-013 SHALL give a latency of exactly 3 cycles from the accept cycle (in_valid && in_ready) to out_valid when out_ready is held high.
REQ-014 SHALL define advance = !out_valid || out_ready; every stage SHALL load only when advance is high, and in_ready SHALL equal advance.
REQ-015 SHALL sustain 1 result/cycle under continuous in_valid and out_ready, hold at most 3 items in flight, and neither drop nor duplicate an item.
REQ-016 SHALL keep result and flags stable while out_valid && !out_ready.
REQ-017 SHALL insert a bubble (stage valid=0) when in_valid=0 on an advance cycle.
REQ-018 SHALL compute sign = sign_a XOR sign_b for every non-NaN result.
REQ-019 SHALL form the exponent as ea+eb-BIAS, BIAS = 2^(EXP_W-1)-1, in signed EXP_W+2 bits so that no wrap occurs.
REQ-020 SHALL, when the product MSB (bit 2*MAN_W+1) is 1, take the mantissa from the upper bits and add 1 to the exponent; otherwise it SHALL shift by one and leave the exponent unchanged.
REQ-021 SHALL treat exp=0 inputs (zero or denormal) as signed zero (flush-to-zero).
REQ-022 SHALL, when either input is NaN, or the inputs are Inf×0, return canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0) with invalid=1.
REQ-023 SHALL return signed Inf with no flags for Inf × finite non-zero.
REQ-024 SHALL return signed zero with no flags for zero × finite.
REQ-025 SHALL, when the final biased exponent is ≥ all-ones, return signed Inf with overflow=1; this check SHALL apply after the rounding carry.
REQ-026 SHALL, when the final biased exponent is ≤ 0, return signed zero with underflow=1.
REQ-027 SHALL, on a rounding carry-out from the mantissa, set the mantissa to 0 and add 1 to the exponent.

Reset
REQ-028 SHALL clear all stage valids, out_valid, result and flags to 0 on rst; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-029 SHALL discard all in-flight items when rst is asserted mid-operation, produce no output for them, and give rst priority over advance.

Configuration
REQ-030 SHALL round to nearest, ties-to-even, using guard plus sticky (OR of all lower product bits), when FP_MUL_ROUND_EN is defined.
REQ-031 SHALL truncate, as in the previous generation, when FP_MUL_ROUND_EN is undefined; latency and interface SHALL be identical in both builds.

Structure
REQ-032 SHALL place in package fp_mul_pkg: the flags struct (invalid/overflow/underflow), the operand-class enum (ZERO, NORM, INF, NAN), and the width-derived BIAS/canonical-NaN helper functions.
REQ-033 SHALL implement S1 classification in sub-module fp_mul_unpack (one instance per operand); the pipeline registers SHALL stay in fp_mul_pipe.

Verification
REQ-034 SHALL verify: a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> result 0x40400000, flags 000, out_valid exactly 3 cycles after accept.
REQ-035 SHALL verify: a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid=1; and a=0xFF800000, b=0x40000000 -> 0xFF800000, flags 000.
REQ-036 SHALL verify: a=b=0x7F000000 -> 0x7F800000, overflow=1; and a=b=0x00800000 -> 0x00000000, underflow=1.
REQ-037 SHALL verify: a=0x3FC00000, b=0x3F800001 -> 0x3FC00002 with FP_MUL_ROUND_EN defined, and 0x3FC00001 without it.
REQ-038 SHALL verify: stream 5 products with out_ready=0 for 6 cycles -> in_ready drops after 3 accepts, the output holds the first result, and all 5 results emerge in order once out_ready=1.
REQ-039 SHALL verify: assert rst for 1 cycle with 2 items in flight -> no out_valid for them, and the next accepted item returns its result after 3 cycles.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg -- shared types and width-derived helpers for the pipelined
// floating-point multiplier.
//   fp_flags_t : {invalid, overflow, underflow} status bits, MSB first.
//   fp_class_t : operand class produced by the S1 unpack stage.
//   fp_bias()  : exponent bias 2^(exp_w-1)-1.
//   fp_qnan()  : canonical quiet NaN (sign 0, exp all-ones, man MSB set),
//                returned right-aligned in a wide vector for the caller to
//                truncate to its own word width.
package fp_mul_pkg;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    localparam int FP_MAX_W = 128;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
        v = v | (FP_MAX_W'(1) << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_unpack.sv
// fp_mul_unpack -- splits one operand into fields and classifies it.
// Ports:
//   i_op    : operand word {sign, exp, man}
//   o_sign  : sign bit
//   o_exp   : biased exponent field
//   o_man   : mantissa with hidden bit restored (MAN_W+1 bits)
//   o_cls   : ZERO (exp==0, denormals flushed), NORM, INF or NAN
module fp_mul_unpack
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_man,
    output fp_class_t            o_cls
);

    logic [MAN_W-1:0] w_frac;
    logic             w_exp_ones;
    logic             w_exp_zero;

    assign o_sign     = i_op[EXP_W+MAN_W];
    assign o_exp      = i_op[EXP_W+MAN_W-1 -: EXP_W];
    assign w_frac     = i_op[MAN_W-1:0];
    assign w_exp_ones = &o_exp;
    assign w_exp_zero = ~|o_exp;

    // The hidden bit is always set: ZERO-class operands never reach the
    // normal datapath result, so their mantissa value is irrelevant.
    assign o_man = {1'b1, w_frac};

    always_comb begin
        o_cls = NORM;
        if (w_exp_ones) begin
            o_cls = (|w_frac) ? NAN : INF;
        end else if (w_exp_zero) begin
            o_cls = ZERO;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- 3-stage pipelined IEEE-style multiplier with valid/ready.
//   S1: unpack/classify both operands, sign XOR, exponent sum ea+eb-BIAS
//   S2: (MAN_W+1)x(MAN_W+1) mantissa product
//   S3: normalise, round, overflow/underflow detect, special-case select
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready == advance)
//   a, b                : operands {sign, exp, man}
//   out_valid/out_ready : result handshake
//   result, flags       : product and {invalid, overflow, underflow}
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even; without
// it the mantissa is truncated. Latency and interface are identical.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int P_W   = 2 * MAN_W + 2;
    localparam int BIAS  = fp_bias(EXP_W);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

    // Exponent arithmetic is carried in signed EXP_W+2 bits so that sums of
    // two large exponents or two small ones never wrap.
    localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] EXP_ONE   = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO  = '0;
    localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'((1 << EXP_W) - 1);

    // ---------------- S1: unpack both operands ----------------
    logic [W-1:0]     w_op   [2];
    logic             w_sign [2];
    logic [EXP_W-1:0] w_exp  [2];
    logic [MAN_W:0]   w_man  [2];
    fp_class_t        w_cls  [2];

    assign w_op[0] = a;
    assign w_op[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            fp_mul_unpack #(
                .EXP_W (EXP_W),
                .MAN_W (MAN_W)
            ) u_unpack (
                .i_op   (w_op[gi]),
                .o_sign (w_sign[gi]),
                .o_exp  (w_exp[gi]),
                .o_man  (w_man[gi]),
                .o_cls  (w_cls[gi])
            );
        end
    endgenerate

    logic                    w_advance;
    logic signed [EXP_W+1:0] w_exp_sum;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_exp_sum = $signed({2'b00, w_exp[0]}) + $signed({2'b00, w_exp[1]}) - BIAS_S;

    // ---------------- pipeline registers ----------------
    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic signed [EXP_W+1:0] r_s1_exp;
    logic [MAN_W:0]          r_s1_man_a;
    logic [MAN_W:0]          r_s1_man_b;
    fp_class_t               r_s1_cls_a;
    fp_class_t               r_s1_cls_b;

    logic                    r_s2_valid;
    logic                    r_s2_sign;
    logic signed [EXP_W+1:0] r_s2_exp;
    logic [P_W-1:0]          r_s2_prod;
    fp_class_t               r_s2_cls_a;
    fp_class_t               r_s2_cls_b;

    logic                    r_out_valid;
    logic [W-1:0]            r_result;
    fp_flags_t               r_flags;

    // ---------------- S3: normalise and round ----------------
    logic                    w_prod_msb;
    logic [MAN_W-1:0]        w_man_norm;
    logic signed [EXP_W+1:0] w_exp_norm;
    logic                    w_round_up;
    logic [MAN_W:0]          w_man_inc;
    logic [MAN_W-1:0]        w_man_fin;
    logic signed [EXP_W+1:0] w_exp_fin;

    // Product of two [1,2) mantissas lies in [1,4): bit 2*MAN_W+1 set means
    // the value is >= 2 and the binary point moves one place left.
    assign w_prod_msb = r_s2_prod[P_W-1];
    assign w_man_norm = w_prod_msb ? r_s2_prod[2*MAN_W -: MAN_W]
                                   : r_s2_prod[2*MAN_W-1 -: MAN_W];
    assign w_exp_norm = w_prod_msb ? r_s2_exp + EXP_ONE : r_s2_exp;

`ifdef FP_MUL_ROUND_EN
    logic w_guard;
    logic w_sticky;

    assign w_guard    = w_prod_msb ? r_s2_prod[MAN_W] : r_s2_prod[MAN_W-1];
    assign w_sticky   = w_prod_msb ? (|r_s2_prod[MAN_W-1:0]) : (|r_s2_prod[MAN_W-2:0]);
    // Nearest-even: round up above half, or exactly half with an odd LSB.
    assign w_round_up = w_guard && (w_sticky || w_man_norm[0]);
`else
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^r_s2_prod[MAN_W-1:0];
    assign w_round_up    = 1'b0;
`endif

    // A carry out of the mantissa means it rolled over to 1.000..0 x 2.
    assign w_man_inc = {1'b0, w_man_norm} + (MAN_W+1)'(w_round_up);
    assign w_man_fin = w_man_inc[MAN_W] ? '0 : w_man_inc[MAN_W-1:0];
    assign w_exp_fin = w_man_inc[MAN_W] ? w_exp_norm + EXP_ONE : w_exp_norm;

    logic      w_any_nan;
    logic      w_any_inf;
    logic      w_any_zero;
    logic [W-1:0] w_res_next;
    fp_flags_t    w_flags_next;

    assign w_any_nan  = (r_s2_cls_a == NAN)  || (r_s2_cls_b == NAN);
    assign w_any_inf  = (r_s2_cls_a == INF)  || (r_s2_cls_b == INF);
    assign w_any_zero = (r_s2_cls_a == ZERO) || (r_s2_cls_b == ZERO);

    always_comb begin
        w_res_next   = {r_s2_sign, w_exp_fin[EXP_W-1:0], w_man_fin};
        w_flags_next = '0;
        if (w_any_nan || (w_any_inf && w_any_zero)) begin
            w_res_next           = QNAN;
            w_flags_next.invalid = 1'b1;
        end else if (w_any_inf) begin
            w_res_next = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_any_zero) begin
            w_res_next = {r_s2_sign, {(W-1){1'b0}}};
        end else if (w_exp_fin >= EXP_MAX_S) begin
            w_res_next            = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags_next.overflow = 1'b1;
        end else if (w_exp_fin <= EXP_ZERO) begin
            w_res_next             = {r_s2_sign, {(W-1){1'b0}}};
            w_flags_next.underflow = 1'b1;
        end
    end

    // Control: valids and output registers; reset wins over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_result <= w_res_next;
                r_flags  <= w_flags_next;
            end
        end
    end

    // Datapath: no reset needed, qualified by the stage valids above.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_sign  <= w_sign[0] ^ w_sign[1];
            r_s1_exp   <= w_exp_sum;
            r_s1_man_a <= w_man[0];
            r_s1_man_b <= w_man[1];
            r_s1_cls_a <= w_cls[0];
            r_s1_cls_b <= w_cls[1];

            r_s2_sign  <= r_s1_sign;
            r_s2_exp   <= r_s1_exp;
            r_s2_cls_a <= r_s1_cls_a;
            r_s2_cls_b <= r_s1_cls_b;
            r_s2_prod  <= {{(MAN_W+1){1'b0}}, r_s1_man_a} * {{(MAN_W+1){1'b0}}, r_s1_man_b};
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
